alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 135 +++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub, iterative shift-add multiply and
// restoring divide sharing one hi/lo working register pair.
module alu_mc #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         oper,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out,
    output logic               dz
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic             isdiv;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   addsum;
    logic [WIDTH:0]   subdiff;
    logic [WIDTH:0]   mulsum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] hinext;
    logic [WIDTH-1:0] lonext;
    logic             ge;
    logic             accept;

    // Mul keeps {hi,lo} as partial product / multiplier; div keeps it as
    // remainder / dividend-becoming-quotient, so both finish as {hi,lo}.
    always_comb begin
        addsum  = {1'b0, in1} + {1'b0, in2};
        subdiff = {1'b0, in1} - {1'b0, in2};
        mulsum  = {1'b0, hi} + (lo[0] ? {1'b0, a} : '0);
        shifted = {hi, lo[WIDTH-1]};
        ge      = shifted >= {1'b0, a};
        trial   = shifted[WIDTH-1:0] - a;
        if (isdiv) begin
            hinext = ge ? trial : shifted[WIDTH-1:0];
            lonext = {lo[WIDTH-2:0], ge};
        end else begin
            hinext = mulsum[WIDTH:1];
            lonext = {mulsum[0], lo[WIDTH-1:1]};
        end
    end

    assign accept = start && (state != RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            isdiv <= 1'b0;
            a     <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dz    <= 1'b0;
        end else if (accept) begin
            dz    <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
            isdiv <= oper[1];
            hi    <= '0;
            cnt   <= '0;
            case (oper)
                2'b00: begin
                    out   <= {{(WIDTH-1){1'b0}}, addsum};
                    state <= DONE;
                    done  <= 1'b1;
                end
                2'b10: begin
                    out   <= {{(WIDTH-1){subdiff[WIDTH]}}, subdiff};
                    state <= DONE;
                    done  <= 1'b1;
                end
                2'b01: begin
                    a     <= in1;
                    lo    <= in2;
                    state <= RUN;
                    busy  <= 1'b1;
                end
                default: begin
                    if (in2 == '0) begin
                        out   <= '0;
                        dz    <= 1'b1;
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        a     <= in2;
                        lo    <= in1;
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
            endcase
        end else begin
            case (state)
                RUN: begin
                    hi  <= hinext;
                    lo  <= lonext;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        out   <= {hinext, lonext};
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
